// File: rtl/dma_axi_master_buf_if.sv
// AXI4 master-side channel bundle for the buffered DMA burst master.
// Signal names keep the AXI channel naming of the bus they connect to.
interface dma_axi_master_buf_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     AWID_M;
  logic [ADDR_W-1:0]   AWADDR_M;
  logic [LEN_W-1:0]    AWLEN_M;
  logic [2:0]          AWSIZE_M;
  logic [1:0]          AWBURST_M;
  logic                AWVALID_M;
  logic                AWREADY_M;

  logic [DATA_W-1:0]   WDATA_M;
  logic [DATA_W/8-1:0] WSTRB_M;
  logic                WLAST_M;
  logic                WVALID_M;
  logic                WREADY_M;

  logic [ID_W-1:0]     BID_M;
  logic [1:0]          BRESP_M;
  logic                BVALID_M;
  logic                BREADY_M;

  logic [ID_W-1:0]     ARID_M;
  logic [ADDR_W-1:0]   ARADDR_M;
  logic [LEN_W-1:0]    ARLEN_M;
  logic [2:0]          ARSIZE_M;
  logic [1:0]          ARBURST_M;
  logic                ARVALID_M;
  logic                ARREADY_M;

  logic [ID_W-1:0]     RID_M;
  logic [DATA_W-1:0]   RDATA_M;
  logic [1:0]          RRESP_M;
  logic                RLAST_M;
  logic                RVALID_M;
  logic                RREADY_M;

  modport master (
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BID_M, BRESP_M, BVALID_M,
    output BREADY_M,
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M
  );

  modport slave (
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BID_M, BRESP_M, BVALID_M,
    input  BREADY_M,
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M
  );
endinterface

// File: rtl/dma_axi_master_buf.sv
// Buffered AXI4 burst master: independent read/write FSMs, each with a data FIFO
// decoupling the DMA-side stream from the AXI handshake.
module dma_axi_master_buf #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned ID_VAL      = 0,
  parameter int unsigned RFIFO_DEPTH = 4,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,

  input  logic              i_rd_req,
  output logic              o_rd_req_rdy,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [LEN_W-1:0]  i_rd_len,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic              o_rd_err,

  input  logic              i_wr_req,
  output logic              o_wr_req_rdy,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [LEN_W-1:0]  i_wr_len,
  input  logic              i_wd_valid,
  output logic              o_wd_ready,
  input  logic [DATA_W-1:0] i_wd_data,
  output logic              o_wr_done,
  output logic              o_wr_err,

  output logic              o_rd_idle,
  output logic              o_wr_idle,

  dma_axi_master_buf_if.master axi
);

  localparam int unsigned RAW = $clog2(RFIFO_DEPTH);
  localparam int unsigned WAW = $clog2(WFIFO_DEPTH);
  localparam logic [2:0]  AXSIZE = 3'($clog2(DATA_W/8));
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [RAW:0]   RPTR_ONE = (RAW+1)'(1);
  localparam logic [WAW:0]   WPTR_ONE = (WAW+1)'(1);
  localparam logic [LEN_W:0] CNT_ONE  = (LEN_W+1)'(1);

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_t;

  // ---------------------------------------------------------------- read path
  rd_state_t         rd_state, rd_next;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LEN_W-1:0]  rd_len_q;

  logic [DATA_W+1:0] rmem [RFIFO_DEPTH];
  logic [RAW:0]      rwp, rrp;
  logic              rfull, rempty, rpush, rpop;
  logic [DATA_W+1:0] rhead;

  assign rfull  = (rwp[RAW] != rrp[RAW]) && (rwp[RAW-1:0] == rrp[RAW-1:0]);
  assign rempty = (rwp == rrp);
  assign rpush  = axi.RVALID_M && axi.RREADY_M;
  assign rpop   = !rempty && i_rd_ready;
  assign rhead  = rmem[rrp[RAW-1:0]];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_addr_q <= '0;
      rd_len_q  <= '0;
    end else if (i_rd_req && rd_state == RD_IDLE) begin
      rd_addr_q <= i_rd_addr;
      rd_len_q  <= i_rd_len;
    end
  end

  always_comb begin
    rd_next       = rd_state;
    o_rd_req_rdy  = 1'b0;
    axi.ARVALID_M = 1'b0;
    axi.RREADY_M  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        o_rd_req_rdy = 1'b1;
        if (i_rd_req) rd_next = RD_AR;
      end
      RD_AR: begin
        axi.ARVALID_M = 1'b1;
        if (axi.ARREADY_M) rd_next = RD_DATA;
      end
      RD_DATA: begin
        axi.RREADY_M = !rfull;
        if (axi.RVALID_M && !rfull && axi.RLAST_M) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rwp <= '0;
      rrp <= '0;
    end else begin
      if (rpush) rwp <= rwp + RPTR_ONE;
      if (rpop)  rrp <= rrp + RPTR_ONE;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge ACLK) begin
    if (rpush) rmem[rwp[RAW-1:0]] <= {axi.RDATA_M, axi.RLAST_M, axi.RRESP_M[1]};
  end

  assign o_rd_valid = !rempty;
  assign o_rd_data  = rempty ? '0 : rhead[DATA_W+1:2];
  assign o_rd_last  = !rempty && rhead[1];
  assign o_rd_err   = !rempty && rhead[0];
  assign o_rd_idle  = (rd_state == RD_IDLE) && rempty;

  assign axi.ARID_M    = ID_W'(ID_VAL);
  assign axi.ARADDR_M  = rd_addr_q;
  assign axi.ARLEN_M   = rd_len_q;
  assign axi.ARSIZE_M  = AXSIZE;
  assign axi.ARBURST_M = BURST_INCR;

  // --------------------------------------------------------------- write path
  wr_state_t         wr_state, wr_next;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [LEN_W-1:0]  wr_len_q;
  logic [LEN_W:0]    push_cnt, send_cnt;
  logic              wr_accept;

  logic [DATA_W-1:0] wmem [WFIFO_DEPTH];
  logic [WAW:0]      wwp, wrp;
  logic              wfull, wempty, wpush, wpop, wvalid, wlast, b_hs;

  assign wr_accept = i_wr_req && (wr_state == WR_IDLE);
  assign wfull  = (wwp[WAW] != wrp[WAW]) && (wwp[WAW-1:0] == wrp[WAW-1:0]);
  assign wempty = (wwp == wrp);

  // Counters are one bit wider than len so a max-length burst ends at len+1 without wrapping.
  assign o_wd_ready = (wr_state != WR_IDLE) && !wfull && (push_cnt <= {1'b0, wr_len_q});
  assign wpush  = i_wd_valid && o_wd_ready;
  assign wvalid = (wr_state == WR_W) && !wempty;
  assign wlast  = wvalid && (send_cnt == {1'b0, wr_len_q});
  assign wpop   = wvalid && axi.WREADY_M;
  assign b_hs   = axi.BVALID_M && axi.BREADY_M;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next       = wr_state;
    o_wr_req_rdy  = 1'b0;
    axi.AWVALID_M = 1'b0;
    axi.BREADY_M  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        o_wr_req_rdy = 1'b1;
        if (i_wr_req) wr_next = WR_AW;
      end
      WR_AW: begin
        axi.AWVALID_M = 1'b1;
        if (axi.AWREADY_M) wr_next = WR_W;
      end
      WR_W: begin
        if (wpop && wlast) wr_next = WR_B;
      end
      WR_B: begin
        axi.BREADY_M = 1'b1;
        if (axi.BVALID_M) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      push_cnt  <= '0;
      send_cnt  <= '0;
    end else if (wr_accept) begin
      wr_addr_q <= i_wr_addr;
      wr_len_q  <= i_wr_len;
      push_cnt  <= '0;
      send_cnt  <= '0;
    end else begin
      if (wpush) push_cnt <= push_cnt + CNT_ONE;
      if (wpop)  send_cnt <= send_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wwp <= '0;
      wrp <= '0;
    end else begin
      if (wpush) wwp <= wwp + WPTR_ONE;
      if (wpop)  wrp <= wrp + WPTR_ONE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wpush) wmem[wwp[WAW-1:0]] <= i_wd_data;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      o_wr_done <= 1'b0;
      o_wr_err  <= 1'b0;
    end else begin
      o_wr_done <= b_hs;
      o_wr_err  <= b_hs && axi.BRESP_M[1];
    end
  end

  assign o_wr_idle = (wr_state == WR_IDLE);

  assign axi.AWID_M    = ID_W'(ID_VAL);
  assign axi.AWADDR_M  = wr_addr_q;
  assign axi.AWLEN_M   = wr_len_q;
  assign axi.AWSIZE_M  = AXSIZE;
  assign axi.AWBURST_M = BURST_INCR;
  assign axi.WVALID_M  = wvalid;
  assign axi.WDATA_M   = wvalid ? wmem[wrp[WAW-1:0]] : '0;
  assign axi.WLAST_M   = wlast;
  assign axi.WSTRB_M   = '1;

  logic unused_axi;
  assign unused_axi = ^{axi.RID_M, axi.BID_M, axi.RRESP_M[0], axi.BRESP_M[0]};

endmodule
